// File: rtl/comparator_arbiter_if.sv
// -----------------------------------------------------------------------------
// comparator_arbiter_if
// Bundles the requester-side bus of comparator_arbiter. It carries the request
// vector, the packed operand buses, the enable/clear controls and the
// grant/result/statistics outputs.
//   master : requester side (drives req, operands, en, cnt_clr)
//   slave  : arbiter side (drives gnt, rsp_*, match_cnt)
// Operand packing: requester i uses in0_bus/in1_bus[i*WIDTH +: WIDTH].
// -----------------------------------------------------------------------------
interface comparator_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
);
  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in0_bus;
  logic [NREQ*WIDTH-1:0] in1_bus;
  logic                  cnt_clr;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_eq;
  logic [CNTW-1:0]       match_cnt;

  modport master (
    output en, req, in0_bus, in1_bus, cnt_clr,
    input  gnt, rsp_valid, rsp_id, rsp_eq, match_cnt
  );

  modport slave (
    input  en, req, in0_bus, in1_bus, cnt_clr,
    output gnt, rsp_valid, rsp_id, rsp_eq, match_cnt
  );
endinterface

// File: rtl/comparator_arbiter.sv
// -----------------------------------------------------------------------------
// comparator / comparator_arbiter
// comparator: WIDTH-bit equality compare, out_o = (in0_i == in1_i).
// comparator_arbiter: round-robin arbiter that shares one comparator among
// NREQ requesters. At most one grant per cycle. The granted operand pair is
// latched into stage 1, compared combinationally, and the registered result
// comes back one cycle after the grant, tagged with the requester id.
// A saturating counter tracks matching results.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : comparator_arbiter_if.slave (en, req, in0_bus, in1_bus, cnt_clr in;
//          gnt, rsp_valid, rsp_id, rsp_eq, match_cnt out)
// -----------------------------------------------------------------------------
module comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  output logic             out_o
);
  assign out_o = (in0_i == in1_i);
endmodule

module comparator_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  comparator_arbiter_if.slave  bus
);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [IDW-1:0]  LAST_IDX = IDW'(NREQ - 1);

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_eq_q, rsp_eq_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [NREQ-1:0]  eligible;
  logic             found;
  logic [IDW-1:0]   sel;
  logic             cmp_eq;

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .in0_i (s1_a_q),
    .in1_i (s1_b_q),
    .out_o (cmp_eq)
  );

  // A requester is masked in its own grant cycle so one request is never
  // granted twice; holding req past the grant counts as a fresh request.
  assign eligible = bus.req & ~gnt_q;

  // Round-robin scan starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    sel   = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && eligible[(int'(ptr_q) + off) % NREQ]) begin
        found = 1'b1;
        sel   = IDW'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    s1_valid_d  = 1'b0;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    rsp_valid_d = s1_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_eq_d    = rsp_eq_q;
    cnt_d       = cnt_q;

    if (bus.en && found) begin
      gnt_d[sel] = 1'b1;
      s1_valid_d = 1'b1;
      s1_a_d     = bus.in0_bus[int'(sel)*WIDTH +: WIDTH];
      s1_b_d     = bus.in1_bus[int'(sel)*WIDTH +: WIDTH];
      s1_id_d    = sel;
      ptr_d      = (sel == LAST_IDX) ? '0 : sel + 1'b1;
    end

    // Result fields only move with a real result; otherwise they hold.
    if (s1_valid_q) begin
      rsp_id_d = s1_id_q;
      rsp_eq_d = cmp_eq;
    end

    // Clear wins over a coincident increment; the count never wraps.
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (rsp_valid_q && rsp_eq_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= '0;
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_eq_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_eq_q    <= rsp_eq_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_comparator_arbiter.sv
// -----------------------------------------------------------------------------
// tb_comparator_arbiter
// Drives two arbiters (CNTW=16 and CNTW=2) with identical stimulus and checks
// them against a transaction-level reference model: a round-robin pointer,
// a queue of in-flight results keyed by due cycle, and saturating counts.
// -----------------------------------------------------------------------------
module tb_comparator_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [15:0] in0_bus;
  logic [15:0] in1_bus;
  logic        cnt_clr;

  always #5 clk = ~clk;

  comparator_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(16)) ifa ();
  comparator_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(2))  ifb ();

  assign ifa.en = en;  assign ifa.req = req;  assign ifa.cnt_clr = cnt_clr;
  assign ifa.in0_bus = in0_bus;  assign ifa.in1_bus = in1_bus;
  assign ifb.en = en;  assign ifb.req = req;  assign ifb.cnt_clr = cnt_clr;
  assign ifb.in0_bus = in0_bus;  assign ifb.in1_bus = in1_bus;

  comparator_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(16)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  comparator_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(2)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int id;
    bit eq;
  } res_t;

  res_t     pend_q[$];
  int       cyc;
  int       m_ptr;
  bit [3:0] m_gnt;
  int       cnt16, cnt2;
  bit       inc_pend;
  bit       exp_valid;
  int       last_id;
  bit       last_eq;

  task automatic model_reset();
    pend_q.delete();
    m_ptr = 0;  m_gnt = '0;  cnt16 = 0;  cnt2 = 0;
    inc_pend = 0;  exp_valid = 0;  last_id = 0;  last_eq = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    ifa.gnt,       0);
    check({tag, "_valid"},  ifa.rsp_valid, 0);
    check({tag, "_id"},     ifa.rsp_id,    0);
    check({tag, "_eq"},     ifa.rsp_eq,    0);
    check({tag, "_cnt"},    ifa.match_cnt, 0);
    check({tag, "_cnt2"},   ifb.match_cnt, 0);
    check({tag, "_valid2"}, ifb.rsp_valid, 0);
  endtask

  // One clock: the model consumes the inputs that were stable at the edge,
  // then every observable output is compared.
  task automatic step();
    bit [3:0] new_gnt;
    @(posedge clk);
    #1;
    cyc++;
    if (cnt_clr) begin
      cnt16 = 0;
      cnt2  = 0;
    end else if (inc_pend) begin
      cnt16 = (cnt16 < 65535) ? cnt16 + 1 : cnt16;
      cnt2  = (cnt2 < 3) ? cnt2 + 1 : cnt2;
    end
    new_gnt = '0;
    if (en) begin
      for (int off = 0; off < NREQ; off++) begin
        int i;
        i = (m_ptr + off) % NREQ;
        if (req[i] && !m_gnt[i]) begin
          res_t r;
          r.due = cyc + 1;
          r.id  = i;
          r.eq  = (in0_bus[i*WIDTH +: WIDTH] == in1_bus[i*WIDTH +: WIDTH]);
          pend_q.push_back(r);
          new_gnt[i] = 1'b1;
          m_ptr = (i + 1) % NREQ;
          break;
        end
      end
    end
    m_gnt = new_gnt;
    exp_valid = 0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      res_t r;
      r = pend_q.pop_front();
      exp_valid = 1;
      last_id   = r.id;
      last_eq   = r.eq;
    end
    inc_pend = exp_valid && last_eq;

    check("gnt",       ifa.gnt,       m_gnt);
    check("rsp_valid", ifa.rsp_valid, exp_valid);
    check("rsp_id",    ifa.rsp_id,    last_id);
    check("rsp_eq",    ifa.rsp_eq,    last_eq);
    check("match_cnt", ifa.match_cnt, cnt16);
    check("match_cnt_sat", ifb.match_cnt, cnt2);
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    in0_bus[i*WIDTH +: WIDTH] = a;
    in1_bus[i*WIDTH +: WIDTH] = b;
  endtask

  // Mid-cycle asynchronous reset pulse lasting one rising edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1;  en = 1'b0;  req = '0;  cnt_clr = 1'b0;
    in0_bus = '0;  in1_bus = '0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single matching requester.
    en = 1'b1;  req = 4'b0100;  set_op(2, 4'b0011, 4'b0011);
    step();
    check("single_gnt", ifa.gnt, 4'b0100);
    req = '0;
    step();
    step();
    check("single_cnt", ifa.match_cnt, 1);

    // Mismatching requester.
    req = 4'b0001;  set_op(0, 4'b0001, 4'b0010);
    step();
    req = '0;
    repeat (2) step();

    // All four held from reset: strict rotation.
    do_reset("rst_pulse");
    req = 4'b1111;
    for (int k = 0; k < 4; k++) set_op(k, 4'(k), 4'(k));
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_order", ifa.gnt, rr_seq[k]);
    end
    req = '0;
    repeat (2) step();

    // Enable held low, then released, then dropped right after a grant.
    en = 1'b0;  req = 4'b0010;  set_op(1, 4'hA, 4'hA);
    repeat (5) step();
    en = 1'b1;
    step();
    check("en_gnt", ifa.gnt, 4'b0010);
    en = 1'b0;  req = '0;
    step();
    check("en_inflight", ifa.rsp_valid, 1);
    step();

    // Saturation on the narrow counter, then clear against an increment.
    en = 1'b1;  cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    req = 4'b0001;  set_op(0, 4'h5, 4'h5);
    repeat (10) step();
    req = '0;
    repeat (2) step();
    check("sat_cnt16", ifa.match_cnt, 5);
    check("sat_cnt2",  ifb.match_cnt, 3);
    req = 4'b0001;
    step();
    req = '0;
    step();
    cnt_clr = 1'b1;
    step();
    check("clr_prio",  ifa.match_cnt, 0);
    check("clr_prio2", ifb.match_cnt, 0);
    cnt_clr = 1'b0;

    // Reset between grant and result: result dropped, pointer back to 0.
    req = 4'b0010;
    step();
    req = 4'b1001;  set_op(3, 4'h7, 4'h7);  set_op(0, 4'h2, 4'h3);
    do_reset("rst_mid");
    step();
    check("rst_ptr", ifa.gnt, 4'b0001);
    req = 4'b1000;
    step();
    req = '0;
    repeat (2) step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      en      = ($urandom_range(0, 9) != 0);
      req     = 4'($urandom_range(0, 15));
      cnt_clr = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NREQ; i++) begin
        logic [3:0] a;
        a = 4'($urandom_range(0, 15));
        set_op(i, a, ($urandom_range(0, 1) == 1) ? a : 4'($urandom_range(0, 15)));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
